// File: rtl/sn74_pkg.sv
// -----------------------------------------------------------------------------
// Package: sn74_pkg
// Purpose: shared select encodings and strobe polarity for the 74-series
//          selector models (74xx153 style dual 4:1 data selector).
// Contents:
//   SEL_A..SEL_D : select codes picking data input a/b/c/d (sel[1]=B, sel[0]=A)
//   STR_ACTIVE   : strobe level that enables the outputs (active low)
// -----------------------------------------------------------------------------
package sn74_pkg;

  localparam logic [1:0] SEL_A      = 2'b00;
  localparam logic [1:0] SEL_B      = 2'b01;
  localparam logic [1:0] SEL_C      = 2'b10;
  localparam logic [1:0] SEL_D      = 2'b11;
  localparam logic       STR_ACTIVE = 1'b0;

endpackage : sn74_pkg

// File: rtl/sn74_mux4_slice.sv
// -----------------------------------------------------------------------------
// Module: sn74_mux4_slice
// Purpose: one 1-bit 4:1 data selector section with an active-low strobe,
//          purely combinational.
// Ports:
//   a, b, c, d : in  1  data inputs selected by sel = 00 / 01 / 10 / 11
//   sel        : in  2  select code (sel[1]=B MSB, sel[0]=A LSB)
//   str        : in  1  strobe, active low; inactive level forces y low
//   y          : out 1  selected data, gated by the strobe
// -----------------------------------------------------------------------------
module sn74_mux4_slice
  import sn74_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] sel,
  input  logic       str,
  output logic       y
);

  logic data_sel;

  // Pick one of the four data inputs; an unknown select yields X rather
  // than silently favouring one input.
  always_comb begin
    data_sel = 1'b0;
    case (sel)
      SEL_A:   data_sel = a;
      SEL_B:   data_sel = b;
      SEL_C:   data_sel = c;
      SEL_D:   data_sel = d;
      default: data_sel = 1'bx;
    endcase
  end

  // Gate with the strobe as an AND so an inactive strobe dominates to 0,
  // while an unknown strobe propagates X instead of being resolved.
  always_comb begin
    y = (~(str ^ STR_ACTIVE)) & data_sel;
  end

endmodule : sn74_mux4_slice

// File: rtl/sn74xx153_dual_mux4.sv
// -----------------------------------------------------------------------------
// Module: sn74xx153_dual_mux4
// Purpose: model of a 74xx153 dual 4:1 data selector. SECTIONS independent
//          1-bit selectors share sel and the active-low strobe; the TTL-like
//          combinational output is also captured into a register for use by
//          synchronous logic.
// Parameters:
//   SECTIONS : number of 1-bit sections (data/output width), legal 1..32
// Ports:
//   clk     : in  1         clock, out_q samples on the rising edge
//   rst_n   : in  1         asynchronous active-low clear of out_q only
//   a,b,c,d : in  SECTIONS  data inputs 0..3, bit i feeds section i
//   sel     : in  2         common select (sel[1]=B, sel[0]=A)
//   str     : in  1         common strobe, active low; 1 forces out to 0
//   out     : out SECTIONS  combinational selected data
//   out_q   : out SECTIONS  out registered on clk (1 cycle latency)
// -----------------------------------------------------------------------------
module sn74xx153_dual_mux4
  import sn74_pkg::*;
#(
  parameter int SECTIONS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SECTIONS-1:0] a,
  input  logic [SECTIONS-1:0] b,
  input  logic [SECTIONS-1:0] c,
  input  logic [SECTIONS-1:0] d,
  input  logic [1:0]          sel,
  input  logic                str,
  output logic [SECTIONS-1:0] out,
  output logic [SECTIONS-1:0] out_q
);

  logic [SECTIONS-1:0] out_d;

  // Each section only ever sees its own data bits plus the shared controls.
  for (genvar i = 0; i < SECTIONS; i++) begin : g_section
    sn74_mux4_slice u_slice (
      .a   (a[i]),
      .b   (b[i]),
      .c   (c[i]),
      .d   (d[i]),
      .sel (sel),
      .str (str),
      .y   (out[i])
    );
  end

  // Next value of the output register is simply the live selector output.
  always_comb begin
    out_d = out;
  end

  // Output register; the clear is asynchronous and leaves the
  // combinational path untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= {SECTIONS{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

endmodule : sn74xx153_dual_mux4

// File: tb/tb_sn74xx153_dual_mux4.sv
module tb_sn74xx153_dual_mux4;

  localparam int W = 2;

  typedef struct {
    string        tag;
    logic [W-1:0] exp;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic         str;
  logic [W-1:0] out;
  logic [W-1:0] out_q;

  int checks   = 0;
  int failures = 0;

  sb_t out_sb[$];
  sb_t reg_sb[$];

  sn74xx153_dual_mux4 #(.SECTIONS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .sel   (sel),
    .str   (str),
    .out   (out),
    .out_q (out_q)
  );

  // Reference 74xx153 behaviour for the current inputs.
  function automatic logic [W-1:0] model();
    logic [W-1:0] r;
    if (str) r = '0;
    else begin
      unique case (sel)
        2'd0: r = a;
        2'd1: r = b;
        2'd2: r = c;
        default: r = d;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Push the expected combinational output, let it settle, pop and compare.
  task automatic comb_step(input string tag);
    sb_t e;
    out_sb.push_back('{tag, model()});
    #1;
    if (out_sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = out_sb.pop_front();
      check(e.tag, out, e.exp);
    end
  endtask

  // One clock period; expectation captured from inputs before the edge.
  task automatic tick(input string tag);
    sb_t e;
    reg_sb.push_back('{tag, rst_n ? model() : {W{1'b0}}});
    #4 clk = 1'b1;
    #1;
    if (reg_sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = reg_sb.pop_front();
      check(e.tag, out_q, e.exp);
    end
    #5 clk = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    a = 2'b11; b = 2'b10; c = 2'b01; d = 2'b00;
    sel = 2'b00; str = 1'b0;
    #2;
    check("reset_out_q", out_q, 2'b00);
    check("reset_out_live", out, 2'b11);
    rst_n = 1'b1;
    #1;
    tick("release_load");

    // 1: strobe active, select sweep without clock
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      comb_step($sformatf("sweep_str0_sel%0d", s));
    end
    check("sweep_const_d", out, 2'b00);

    // 2: strobe inactive forces zero
    str = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      comb_step($sformatf("sweep_str1_sel%0d", s));
      check("str1_zero", out, 2'b00);
    end

    // 3: {str,sel} counter
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = k[2:0];
      {str, sel} = kv;
      comb_step($sformatf("cnt_%0d", k));
    end

    // 4: register latency and hold
    str = 1'b0; sel = 2'b00;
    comb_step("lat_out");
    tick("lat_edge");
    check("lat_q11", out_q, 2'b11);
    sel = 2'b01;
    comb_step("lat_sel01_out");
    check("lat_q_hold", out_q, 2'b11);
    tick("lat_next_edge");
    check("lat_q10", out_q, 2'b10);

    // strobe pulse mid-cycle: only the value at the edge is captured
    sel = 2'b00; str = 1'b1;
    #2 str = 1'b0;
    tick("str_glitch_edge");

    // 5: async reset mid-run
    check("pre_reset_q", out_q, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_clear_q", out_q, 2'b00);
    check("async_out_kept", out, 2'b11);
    tick("edge_in_reset");
    rst_n = 1'b1;
    #1;
    check("release_no_edge", out_q, 2'b00);
    tick("reload_edge");

    // 6: section independence
    a = 2'b01; sel = 2'b00; str = 1'b0;
    comb_step("indep_base");
    check("indep_bit0", {1'b0, out[0]}, 2'b01);
    check("indep_bit1", {1'b0, out[1]}, 2'b00);
    a[1] = 1'b1;
    comb_step("indep_flip");
    check("indep_bit0_stable", {1'b0, out[0]}, 2'b01);
    check("indep_bit1_flip", {1'b0, out[1]}, 2'b01);

    // every scoreboard entry must have been consumed
    check("sb_out_empty", out_sb.size() == 0 ? 2'b01 : 2'b00, 2'b01);
    check("sb_reg_empty", reg_sb.size() == 0 ? 2'b01 : 2'b00, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sn74xx153_dual_mux4
